// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: walks the fetch PC through a combinational instruction
// memory and buffers (pc, instr) pairs in a small prefetch FIFO for decode.
module instruction_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [31:0]                    imem_addr,
  input  logic [31:0]                    imem_rd,
  input  logic                           fetch_en,
  input  logic                           redirect_valid,
  input  logic [31:0]                    redirect_pc,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [31:0]                    out_instr,
  output logic [31:0]                    out_pc,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   r_pc;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_entry_pc    [DEPTH];
  logic [31:0]   r_entry_instr [DEPTH];

  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_redirect_target;

  assign w_pop             = (r_count != '0) & out_ready;
  assign w_push            = fetch_en & ~redirect_valid & ((r_count < CW'(DEPTH)) | w_pop);
  assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // Control state: redirect wins over push/pop; a pop coinciding with a
  // redirect is simply dropped along with the rest of the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_pc     <= w_redirect_target;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + 32'd4;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entries are cleared on reset so the head reads as zero straight out of reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_entry_pc[gi]    <= '0;
          r_entry_instr[gi] <= '0;
        end else if (w_push && (r_wr_ptr == AW'(gi))) begin
          r_entry_pc[gi]    <= r_pc;
          r_entry_instr[gi] <= imem_rd;
        end
      end
    end
  endgenerate

  assign imem_addr  = r_pc;
  assign out_valid  = (r_count != '0);
  assign out_pc     = r_entry_pc[r_rd_ptr];
  assign out_instr  = r_entry_instr[r_rd_ptr];
  assign fifo_count = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic,
// all checked against a queue-based model of the fetch stream.
module tb_instruction_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_q[$];
  logic [31:0] m_pc;

  instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'd0:   return 32'h0030_0093;
      32'd4:   return 32'h0050_0113;
      32'd8:   return 32'h0070_0193;
      32'd12:  return 32'h0020_81B3;
      default: return {addr[15:0], ~addr[31:16]} ^ 32'hC0DE_0013;
    endcase
  endfunction

  assign imem_rd = mem_word(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check_eq("valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
    check_eq("count", {29'd0, fifo_count}, 32'(m_q.size()));
    check_eq("addr", imem_addr, m_pc);
    if (m_q.size() > 0) begin
      check_eq("out_pc", out_pc, m_q[0][63:32]);
      check_eq("out_instr", out_instr, m_q[0][31:0]);
    end
  endtask

  // One clock: model decides from pre-edge inputs, then DUT is compared after the edge.
  task automatic step();
    bit do_pop, do_push, do_redir;
    logic [31:0] tgt;
    do_pop   = (m_q.size() > 0) && out_ready;
    do_push  = fetch_en && !redirect_valid && ((m_q.size() < DEPTH) || do_pop);
    do_redir = redirect_valid;
    tgt      = {redirect_pc[31:2], 2'b00};
    @(posedge clk);
    #1;
    if (do_redir) begin
      m_q.delete();
      m_pc = tgt;
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    check_model();
    $display("[TB] t=%0t valid=%0b pc=%h instr=%h count=%0d addr=%h", $time, out_valid, out_pc, out_instr, fifo_count, imem_addr);
  endtask

  task automatic do_reset();
    #3 rst = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    m_q.delete();
    m_pc = RESET_PC;
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_pc", out_pc, 32'd0);
    check_eq("rst_instr", out_instr, 32'd0);
    check_eq("rst_addr", imem_addr, RESET_PC);
    rst = 1'b1;
  endtask

  initial begin
    m_pc = RESET_PC;

    // Reset release, streaming the four known words
    fetch_en = 1'b1; out_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("t1_valid", {31'd0, out_valid}, 32'd1);
      check_eq("t1_pc", out_pc, 32'(4 * k));
    end

    // Back-pressure fills the FIFO, then drains without gaps
    out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) step();
    check_eq("t2_count", {29'd0, fifo_count}, 32'd4);
    check_eq("t2_addr", imem_addr, 32'h10);
    check_eq("t2_head", out_pc, 32'd0);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq("t2_seq", out_pc, 32'(4 * k));
    end

    // Redirect with simultaneous pop while holding PCs 8..20
    out_ready = 1'b0; fetch_en = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) step();
    fetch_en = 1'b0; out_ready = 1'b1;
    step(); step();
    fetch_en = 1'b1; out_ready = 1'b0;
    step(); step();
    check_eq("t3_count_pre", {29'd0, fifo_count}, 32'd4);
    check_eq("t3_head_pre", out_pc, 32'd8);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    step();
    redirect_valid = 1'b0;
    check_eq("t3_count", {29'd0, fifo_count}, 32'd0);
    check_eq("t3_valid", {31'd0, out_valid}, 32'd0);
    step();
    check_eq("t3_tgt_pc", out_pc, 32'h40);
    check_eq("t3_tgt_instr", out_instr, mem_word(32'h40));

    // Fetch stall: drain two entries, PC frozen, then resume
    fetch_en = 1'b1; out_ready = 1'b1;
    do_reset();
    step(); step();
    fetch_en = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check_eq("t4_valid", {31'd0, out_valid}, 32'd0);
    check_eq("t4_addr", imem_addr, 32'd8);
    fetch_en = 1'b1;
    step();
    check_eq("t4_resume", out_pc, 32'd8);

    // Redirect near the top of the address space wraps to zero
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    step(); check_eq("t5_pc0", out_pc, 32'hFFFF_FFF8);
    step(); check_eq("t5_pc1", out_pc, 32'hFFFF_FFFC);
    step(); check_eq("t5_pc2", out_pc, 32'h0000_0000);

    // Asynchronous reset mid-stream takes effect before the next edge
    out_ready = 1'b0; fetch_en = 1'b1;
    do_reset();
    step(); step(); step();
    check_eq("t6_count_pre", {29'd0, fifo_count}, 32'd3);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_valid", {31'd0, out_valid}, 32'd0);
    check_eq("t6_addr", imem_addr, RESET_PC);
    check_eq("t6_count", {29'd0, fifo_count}, 32'd0);
    do_reset();

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      fetch_en       = ($urandom_range(0, 9) < 8);
      out_ready      = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
